// File: rtl/nibble_ser_pkg.sv
// Shared types and default sizes for the nibble serializer.
// Frame length depends on NIBBLE_SER_PARITY_EN (adds one even-parity bit).
package nibble_ser_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned PTR_W_DEF  = 2;

`ifdef NIBBLE_SER_PARITY_EN
  localparam int unsigned PARITY_W = 1;
`else
  localparam int unsigned PARITY_W = 0;
`endif

  localparam int unsigned FRAME_W = DATA_W_DEF + PARITY_W;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/nibble_fifo.sv
// Small synchronous FIFO with occupancy count; a push while full is accepted
// only when a pop happens in the same cycle.
module nibble_fifo
  import nibble_ser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data_c,
  output logic [PTR_W:0]    count,
  output logic              full_c,
  output logic              empty_c
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full_c    = (count == DEPTH_C);
  assign empty_c   = (count == '0);
  assign push_ok   = push & (~full_c | pop);
  assign pop_ok    = pop & ~empty_c;
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Samples upstream nibbles on rising edges of in_clk, queues them, and shifts
// each out MSB first under valid/ready. NIBBLE_SER_PARITY_EN appends even parity.
module nibble_serializer
  import nibble_ser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_clk,
  output logic              ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic [PTR_W:0]    fifo_count,
  output logic              overflow
);

  localparam int unsigned FW    = DATA_W + PARITY_W;
  localparam int unsigned CNT_W = $clog2(FW);

  state_t            state, state_n;
  logic [FW-1:0]     shreg, shreg_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic              in_clk_d;
  logic              strobe;
  logic              pop_c;
  logic              full_c;
  logic              empty_c;
  logic [DATA_W-1:0] head_c;
  logic [FW-1:0]     load_word;

  assign strobe = in_clk & ~in_clk_d;

`ifdef NIBBLE_SER_PARITY_EN
  assign load_word = {head_c, ^head_c};
`else
  assign load_word = head_c;
`endif

  nibble_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (strobe),
    .pop       (pop_c),
    .wr_data   (in_data),
    .rd_data_c (head_c),
    .count     (fifo_count),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

  // Next-state: load from FIFO when idle, shift on each accepted bit.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_c) begin
          pop_c     = 1'b1;
          shreg_n   = load_word;
          bit_cnt_n = CNT_W'(FW - 1);
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (bit_cnt != '0) begin
            shreg_n   = {shreg[FW-2:0], 1'b0};
            bit_cnt_n = bit_cnt - CNT_W'(1);
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and registered serial outputs derived from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      in_clk_d  <= 1'b0;
      ser_valid <= 1'b0;
      ser_data  <= 1'b0;
      ser_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      in_clk_d  <= in_clk;
      ser_valid <= (state_n == SHIFT);
      ser_data  <= (state_n == SHIFT) & shreg_n[FW-1];
      ser_last  <= (state_n == SHIFT) && (bit_cnt_n == '0);
      overflow  <= overflow | (strobe & full_c & ~pop_c);
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed and randomized bench for nibble_serializer; frames are collected
// from accepted handshakes and compared with an expected-nibble queue.
module tb_nibble_serializer;

  localparam int unsigned DEPTH = 4;
`ifdef NIBBLE_SER_PARITY_EN
  localparam int FW = 5;
`else
  localparam int FW = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_clk;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;
  logic [2:0] fifo_count;
  logic       overflow;

  always #25 clk = ~clk;

  nibble_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_clk     (in_clk),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_last   (ser_last),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int         checks = 0;
  int         errors = 0;
  bit         rnd_ready = 1'b0;
  logic [7:0] frame_q[$];
  int         nbits_q[$];
  logic [3:0] exp_q[$];
  int         frames_done = 0;
  bit         valid_seen = 1'b0;

  // Assemble frames from bits accepted at the following rising edge.
  initial begin : monitor
    logic [7:0] acc;
    int         nb;
    acc = '0;
    nb  = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        acc = '0;
        nb  = 0;
      end else begin
        if (ser_valid) valid_seen = 1'b1;
        if (ser_valid && ser_ready) begin
          acc = {acc[6:0], ser_data};
          nb++;
          if (ser_last) begin
            frame_q.push_back(acc);
            nbits_q.push_back(nb);
            frames_done++;
            acc = '0;
            nb  = 0;
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_frame(input logic [3:0] d);
`ifdef NIBBLE_SER_PARITY_EN
    return 32'({d, ^d});
`else
    return 32'(d);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) ser_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] d, input int hi, input int lo);
    in_data = d;
    in_clk  = 1'b1;
    repeat (hi) tick();
    in_clk = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic drain(input string tag);
    int n;
    logic [7:0] f;
    int b;
    logic [3:0] e;
    n = 0;
    while (frame_q.size() < exp_q.size() && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_frames"}, 32'(frame_q.size()), 32'(exp_q.size()));
    while (frame_q.size() > 0 && exp_q.size() > 0) begin
      f = frame_q.pop_front();
      b = nbits_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_value"}, 32'(f), exp_frame(e));
      check({tag, "_bits"}, 32'(b), 32'(FW));
    end
    frame_q.delete();
    nbits_q.delete();
    exp_q.delete();
    repeat (2) tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #30;
    rst = 1'b0;
    tick();
    frame_q.delete();
    nbits_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #(50 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] fr;
    int sent;
    int base;
    int n;
    rst       = 1'b1;
    in_clk    = 1'b0;
    in_data   = '0;
    ser_ready = 1'b1;

    // Reset values during and after reset
    #30;
    check("rst_valid", 32'(ser_valid), 0);
    check("rst_data", 32'(ser_data), 0);
    check("rst_last", 32'(ser_last), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("post_rst_valid", 32'(ser_valid), 0);
      check("post_rst_count", 32'(fifo_count), 0);
    end

    // Single sample 1011 with exact latency
    fr = exp_frame(4'hB);
    exp_q.push_back(4'hB);
    in_data = 4'hB;
    in_clk  = 1'b1;
    tick();
    check("single_lat_valid", 32'(ser_valid), 0);
    check("single_lat_count", 32'(fifo_count), 1);
    tick();
    in_clk = 1'b0;
    check("single_first_valid", 32'(ser_valid), 1);
    check("single_first_data", 32'(ser_data), 32'(fr[FW-1]));
    check("single_first_last", 32'(ser_last), 0);
    for (int i = 1; i < FW; i++) begin
      tick();
      check("single_bit_valid", 32'(ser_valid), 1);
      check("single_bit_data", 32'(ser_data), 32'(fr[FW-1-i]));
      check("single_bit_last", 32'(ser_last), (i == FW - 1) ? 32'd1 : 32'd0);
    end
    tick();
    check("single_gap_valid", 32'(ser_valid), 0);
    drain("single");

    // Backpressure on the first bit of 0110
    exp_q.push_back(4'h6);
    in_data = 4'h6;
    in_clk  = 1'b1;
    tick();
    tick();
    in_clk = 1'b0;
    check("bp_first_valid", 32'(ser_valid), 1);
    ser_ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_hold_valid", 32'(ser_valid), 1);
      check("bp_hold_data", 32'(ser_data), 0);
      check("bp_hold_last", 32'(ser_last), 0);
    end
    ser_ready = 1'b1;
    drain("bp");

    // Overflow: fill shreg and FIFO, then drop one sample
    ser_ready = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      pulse(4'(d), 2, 2);
      exp_q.push_back(4'(d));
    end
    check("ovf_full_count", 32'(fifo_count), 4);
    check("ovf_not_yet", 32'(overflow), 0);
    check("ovf_loaded_valid", 32'(ser_valid), 1);
    check("ovf_loaded_data", 32'(ser_data), 32'(exp_frame(4'h1) >> (FW - 1)));
    pulse(4'h6, 2, 2);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count_held", 32'(fifo_count), 4);
    ser_ready = 1'b1;
    drain("ovf");
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_empty", 32'(fifo_count), 0);

    // Counting stream 0..F then 0, pointers wrap
    do_reset();
    check("reset_clears_ovf", 32'(overflow), 0);
    for (int i = 0; i < 17; i++) begin
      pulse(4'(i % 16), 5, 5);
      exp_q.push_back(4'(i % 16));
    end
    drain("count");
    check("count_no_ovf", 32'(overflow), 0);

    // Random data and random backpressure, FIFO never allowed to overflow
    do_reset();
    rnd_ready = 1'b1;
    sent = 0;
    base = frames_done;
    for (int k = 0; k < 40; k++) begin
      logic [3:0] d;
      n = 0;
      while ((sent - (frames_done - base)) >= int'(DEPTH) && n < 1000) begin
        tick();
        n++;
      end
      if (n >= 1000) check("rand_wait_timeout", 32'(n), 0);
      d = 4'($urandom_range(0, 15));
      pulse(d, 2, $urandom_range(1, 4));
      exp_q.push_back(d);
      sent++;
    end
    drain("rand");
    rnd_ready = 1'b0;
    ser_ready = 1'b1;
    check("rand_no_ovf", 32'(overflow), 0);

    // Reset during the 2nd bit of frame A with two entries queued
    ser_ready = 1'b0;
    pulse(4'hA, 2, 2);
    pulse(4'hB, 2, 2);
    pulse(4'hC, 2, 2);
    check("mid_queued", 32'(fifo_count), 2);
    ser_ready = 1'b1;
    tick();
    check("mid_second_valid", 32'(ser_valid), 1);
    check("mid_second_data", 32'(ser_data), 32'(exp_frame(4'hA) >> (FW - 2)) & 32'd1);
    #10;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(ser_valid), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    #20;
    rst = 1'b0;
    frame_q.delete();
    nbits_q.delete();
    valid_seen = 1'b0;
    repeat (30) tick();
    check("mid_no_residual_valid", 32'(valid_seen), 0);
    check("mid_no_residual_frames", 32'(frame_q.size()), 0);
    check("mid_count_zero", 32'(fifo_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
Name: nibble_serializer

Overview:
- Downstream consumer of the 4-bit divided-clock stage, which produces `out[3:0]` and `clk_out`.
- Samples the upstream nibble on each rising edge of the upstream `clk_out`, detected synchronously in the `clk` domain.
- Buffers sampled nibbles in a small FIFO and shifts each one out serially, MSB first, under a per-bit valid/ready handshake.
- Feeds the serial link / monitor logic that follows.

Parameters:
- DATA_W, 4, nibble width; must match the upstream `out` width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock (20 MHz in bench).
- rst  input  1  asynchronous active-high reset.
- in_data  input  DATA_W  nibble from upstream `out`.
- in_clk  input  1  upstream `clk_out`; synchronous to `clk`, a multiple-cycle-wide level.
- ser_data  output  1  current serial bit.
- ser_valid  output  1  `ser_data` is valid.
- ser_ready  input  1  downstream accepts the bit at the `clk` edge where valid & ready.
- ser_last  output  1  current bit is the final bit of the frame.
- fifo_count  output  PTR_W+1  occupied entries, 0..DEPTH.
- overflow  output  1  sticky: a sample was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - `ser_data`, `ser_valid`, `ser_last`, `fifo_count`, `overflow` all 0.
  - Pointers 0, shift state IDLE, edge-detect register 0.
  - Reset mid-frame aborts the frame and discards all FIFO contents.
- Edge detect:
  - `in_clk_d` is registered from `in_clk`.
  - `strobe = in_clk & ~in_clk_d`: exactly one `clk` cycle per upstream rising edge.
  - `in_data` is sampled in the strobe cycle.
- FIFO:
  - Push on strobe when `fifo_count < DEPTH`, or when full with a pop in the same cycle (count unchanged).
  - Strobe while full with no pop: sample dropped and `overflow` set to 1. It holds until `rst`.
  - Pointers wrap modulo DEPTH.
  - Pop occurs only on the IDLE -> SHIFT load.
- Shift FSM (2 states):
  - IDLE:
    - `ser_valid` = 0.
    - If `fifo_count != 0`: pop the head into `shreg`, set `bit_cnt` = FRAME_W-1, go to SHIFT.
  - SHIFT:
    - `ser_valid` = 1 and `ser_data = shreg[MSB]`.
    - `ser_last` = 1 when `bit_cnt == 0`.
    - On valid & ready with `bit_cnt != 0`: shift left and decrement `bit_cnt`.
    - On valid & ready with `bit_cnt == 0`: go to IDLE.
    - With `ser_ready` low, all outputs hold.
  - FRAME_W = DATA_W (DATA_W+1 with PARITY_EN).
  - There is always one IDLE cycle between frames.
- Latency:
  - Strobe in cycle N; entry written at end of N.
  - Load at end of N+1 (from an empty FIFO); first `ser_valid` in cycle N+2.
- Throughput: with ready tied high, one frame per FRAME_W+1 cycles. Upstream strobes arrive every 2 `clk` periods or more slowly.

Optional Feature:
- Macro `NIBBLE_SER_PARITY_EN`.
- When defined:
  - An even-parity bit (XOR of the nibble) is appended after the LSB; the frame is DATA_W+1 bits.
  - `ser_last` asserts on the parity bit.
- When undefined: frame is DATA_W bits and no parity logic is present.

Decomposition:
- Shared package `nibble_ser_pkg` holds:
  - state enum {IDLE, SHIFT};
  - DATA_W and DEPTH defaults;
  - FRAME_W localparam derived from the macro.
- One natural sub-module, `nibble_fifo`: synchronous FIFO with push/pop, count and full/empty outputs.
- Edge detect and FSM stay in the top level.

Test Plan:
- Reset: `rst`=1 for 30 ns, then release -> all outputs 0, `fifo_count`=0, `ser_valid`=0 until the first strobe.
- Single sample:
  - Stimulus: `in_data`=4'b1011, one `in_clk` rise, `ser_ready`=1.
  - Response: `ser_valid` 2 cycles after the strobe; bits 1,0,1,1 on consecutive cycles; `ser_last` on the 4th bit.
  - With parity: 5th bit is 1.
- Backpressure:
  - Stimulus: `in_data`=4'h6, `ser_ready` low for 3 cycles after the first valid bit.
  - Response: `ser_data`=0 holds for those 3 cycles; the sequence 0,1,1,0 completes unchanged.
- Overflow:
  - Stimulus: `ser_ready`=0, 5 strobes with `in_data` 1,2,3,4,5.
  - Response:
    - First sample 1 is loaded into `shreg`; samples 2,3,4,5 fill the FIFO to `fifo_count`=4.
    - A 6th strobe (`in_data`=6) sets `overflow`=1 and is dropped.
    - After `ser_ready`=1, frames 1,2,3,4,5 emerge in order.
- Counting stream: `in_data` increments 0..15 and wraps to 0, one strobe every 10 cycles, ready high -> 16 frames match 0..F, then 0; no overflow; FIFO pointers wrap.
- Reset mid-frame:
  - Stimulus: assert `rst` during the 2nd bit of frame 4'hA with 2 entries queued.
  - Response: `ser_valid` drops immediately and `fifo_count`=0; no residual frame after release.
